// File: rtl/axi_tg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_tg_pkg                                                               |
// | Shared types, AXI constants and data-pattern function for axi_tg_m.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axi_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_NEXT = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // 32-bit pattern word for beat b of burst k; wraps modulo 2^32.
  function automatic logic [31:0] pat_word(input logic [31:0] seed,
                                           input logic [31:0] burst_idx,
                                           input logic [31:0] beat_idx,
                                           input logic [31:0] burst_len);
    return seed + burst_idx * burst_len + beat_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_tg_pat_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_tg_pat_gen                                                           |
// | Replicates the 32-bit pattern word across the full AXI data width.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_tg_pat_gen
  import axi_tg_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 16
) (
  input  logic [31:0]       seed,
  input  logic [31:0]       burst_idx,
  input  logic [31:0]       beat_idx,
  output logic [DATA_W-1:0] pattern
);

  logic [31:0] word;

  assign word = pat_word(seed, burst_idx, beat_idx, 32'(BURST_LEN));

  for (genvar i = 0; i < DATA_W / 32; i++) begin : g_rep
    assign pattern[i*32 +: 32] = word;
  end

endmodule
`default_nettype wire

// File: rtl/axi_tg_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_tg_m                                                                 |
// | AXI4 write/read-back traffic generator. Define AXI_TG_CHECK_EN to add    |
// | the AR/R read-back and data comparison after every write burst.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_tg_m
  import axi_tg_pkg::*;
#(
  parameter int                DATA_W    = 128,
  parameter int                ADDR_W    = 64,
  parameter int                BURST_LEN = 16,
  parameter int                BURST_NUM = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  loop,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           err_cnt,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [3:0]            awcache,
  output logic [1:0]            awid,
  output logic                  awlock,
  output logic [2:0]            awprot,
  output logic [3:0]            awqos,
  output logic [3:0]            awregion,
  output logic [17:0]           awuser,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [3:0]            arcache,
  output logic [1:0]            arid,
  output logic                  arlock,
  output logic [2:0]            arprot,
  output logic [3:0]            arqos,
  output logic [3:0]            arregion,
  output logic [17:0]           aruser,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  localparam int                STRB_W      = DATA_W / 8;
  localparam logic [2:0]        AXI_SIZE    = 3'($clog2(STRB_W));
  localparam logic [7:0]        AXI_LEN     = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * STRB_W);
  localparam logic [31:0]       LAST_BEAT   = 32'(BURST_LEN - 1);
  localparam logic [31:0]       LAST_BURST  = 32'(BURST_NUM - 1);

  state_e              state_q, state_d;
  logic [31:0]         seed_q, seed_d;
  logic [31:0]         burst_q, burst_d;
  logic [31:0]         beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_inc;
  logic                beat_is_last;
  logic [DATA_W-1:0]   pattern;

  // One generator serves both directions: W and R never overlap in time.
  axi_tg_pat_gen #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN)
  ) u_pat_gen (
    .seed      (seed_q),
    .burst_idx (burst_q),
    .beat_idx  (beat_q),
    .pattern   (pattern)
  );

  assign beat_is_last = (beat_q == LAST_BEAT);

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    err_inc   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_AW;
          seed_d  = '0;
          burst_d = '0;
          beat_d  = '0;
          addr_d  = BASE_ADDR;
        end
      end
      ST_AW: begin
        if (awready) begin
          state_d = ST_W;
          beat_d  = '0;
        end
      end
      ST_W: begin
        if (wready) begin
          beat_d = beat_q + 32'd1;
          if (beat_is_last) state_d = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          err_inc = (bresp != AXI_RESP_OKAY);
`ifdef AXI_TG_CHECK_EN
          state_d = ST_AR;
`else
          state_d = ST_NEXT;
`endif
        end
      end
`ifdef AXI_TG_CHECK_EN
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
          beat_d  = '0;
        end
      end
      ST_R: begin
        if (rvalid) begin
          beat_d = beat_q + 32'd1;
          // Overrun beats past the burst end carry no expected data or rlast error.
          err_inc = (rresp != AXI_RESP_OKAY)
                  || ((beat_q <= LAST_BEAT) && (rdata != pattern))
                  || (beat_is_last && !rlast)
                  || ((beat_q < LAST_BEAT) && rlast);
          if (rlast) state_d = ST_NEXT;
        end
      end
`endif
      ST_NEXT: begin
        if (burst_q != LAST_BURST) begin
          state_d = ST_AW;
          burst_d = burst_q + 32'd1;
          addr_d  = addr_q + BURST_BYTES;
        end else if (loop) begin
          state_d = ST_AW;
          seed_d  = seed_q + 32'd1;
          burst_d = '0;
          addr_d  = BASE_ADDR;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d     = err_q | err_inc;
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      seed_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

  assign awvalid  = (state_q == ST_AW);
  assign awaddr   = addr_q;
  assign awlen    = AXI_LEN;
  assign awsize   = AXI_SIZE;
  assign awburst  = AXI_BURST_INCR;
  assign awcache  = 4'b0011;
  assign awid     = 2'b00;
  assign awlock   = 1'b0;
  assign awprot   = 3'b000;
  assign awqos    = 4'b0000;
  assign awregion = 4'b0000;
  assign awuser   = '0;

  assign wvalid = (state_q == ST_W);
  assign wdata  = pattern;
  assign wstrb  = '1;
  assign wlast  = (state_q == ST_W) && beat_is_last;
  assign bready = (state_q == ST_B);

  assign arvalid  = (state_q == ST_AR);
  assign araddr   = addr_q;
  assign arlen    = AXI_LEN;
  assign arsize   = AXI_SIZE;
  assign arburst  = AXI_BURST_INCR;
  assign arcache  = 4'b0011;
  assign arid     = 2'b00;
  assign arlock   = 1'b0;
  assign arprot   = 3'b000;
  assign arqos    = 4'b0000;
  assign arregion = 4'b0000;
  assign aruser   = '0;
  assign rready   = (state_q == ST_R);

`ifndef AXI_TG_CHECK_EN
  logic unused_rd;
  assign unused_rd = ^{arready, rvalid, rdata, rresp, rlast};
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_tg_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_tg_m                                                              |
// | Scoreboard bench for axi_tg_m (BURST_LEN=4 and BURST_LEN=1 instances).   |
// | Expected error counts follow AXI_TG_CHECK_EN.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axi_tg_m;

`ifdef AXI_TG_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int BL = 4;
  localparam int BN = 2;
  localparam logic [37:0] CONSTS = {2'b01, 4'b0011, 2'b00, 1'b0, 3'b0, 4'b0, 4'b0, 18'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, start, start1, loop;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   aw_cnt   = 0;
  bit   bp_en;
  int   corrupt_burst, corrupt_beat, bresp_burst, rresp_burst, rresp_beat;

  logic [63:0]  exp_aw_q[$];
  logic [63:0]  exp_ar_q[$];
  logic [128:0] exp_w_q[$];
  logic [31:0]  exp1_aw_q[$];
  logic [31:0]  exp1_ar_q[$];
  logic [31:0]  exp1_w_q[$];

  // ---------------- DUT 0: DATA_W=128, BURST_LEN=4, BURST_NUM=2 ----------------
  logic busy, done, err, awvalid, awready, awlock, wvalid, wready, wlast;
  logic bvalid, bready, arvalid, arready, arlock, rvalid, rready, rlast;
  logic [15:0]  err_cnt, wstrb;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst, awid, arid, bresp, rresp;
  logic [3:0]   awcache, arcache, awqos, arqos, awregion, arregion;
  logic [17:0]  awuser, aruser;
  logic [127:0] wdata, rdata;

  axi_tg_m #(.DATA_W(128), .ADDR_W(64), .BURST_LEN(BL), .BURST_NUM(BN), .BASE_ADDR(64'h0)) dut (
    .aclk(clk), .areset(areset), .start(start), .loop(loop),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awcache(awcache), .awid(awid), .awlock(awlock), .awprot(awprot),
    .awqos(awqos), .awregion(awregion), .awuser(awuser),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arid(arid), .arlock(arlock), .arprot(arprot),
    .arqos(arqos), .arregion(arregion), .aruser(aruser),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  // ---------------- DUT 1: DATA_W=32, BURST_LEN=1, BURST_NUM=3 ----------------
  logic busy1, done1, err1, awvalid1, awready1, awlock1, wvalid1, wready1, wlast1;
  logic bvalid1, bready1, arvalid1, arready1, arlock1, rvalid1, rready1, rlast1;
  logic [15:0] err_cnt1;
  logic [3:0]  wstrb1;
  logic [31:0] awaddr1, araddr1, wdata1, rdata1;
  logic [7:0]  awlen1, arlen1;
  logic [2:0]  awsize1, arsize1, awprot1, arprot1;
  logic [1:0]  awburst1, arburst1, awid1, arid1, bresp1, rresp1;
  logic [3:0]  awcache1, arcache1, awqos1, arqos1, awregion1, arregion1;
  logic [17:0] awuser1, aruser1;

  axi_tg_m #(.DATA_W(32), .ADDR_W(32), .BURST_LEN(1), .BURST_NUM(3), .BASE_ADDR(32'h100)) dut1 (
    .aclk(clk), .areset(areset), .start(start1), .loop(1'b0),
    .busy(busy1), .done(done1), .err(err1), .err_cnt(err_cnt1),
    .awvalid(awvalid1), .awready(awready1), .awaddr(awaddr1), .awlen(awlen1), .awsize(awsize1),
    .awburst(awburst1), .awcache(awcache1), .awid(awid1), .awlock(awlock1), .awprot(awprot1),
    .awqos(awqos1), .awregion(awregion1), .awuser(awuser1),
    .wvalid(wvalid1), .wready(wready1), .wdata(wdata1), .wstrb(wstrb1), .wlast(wlast1),
    .bvalid(bvalid1), .bready(bready1), .bresp(bresp1),
    .arvalid(arvalid1), .arready(arready1), .araddr(araddr1), .arlen(arlen1), .arsize(arsize1),
    .arburst(arburst1), .arcache(arcache1), .arid(arid1), .arlock(arlock1), .arprot(arprot1),
    .arqos(arqos1), .arregion(arregion1), .aruser(aruser1),
    .rvalid(rvalid1), .rready(rready1), .rdata(rdata1), .rresp(rresp1), .rlast(rlast1)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake seen with no expected entry queued", name);
  endtask

  task automatic push_pass(input int seed);
    for (int k = 0; k < BN; k++) begin
      exp_aw_q.push_back(64'(k * 64));
      if (CHK == 1) exp_ar_q.push_back(64'(k * 64));
      for (int b = 0; b < BL; b++)
        exp_w_q.push_back({(b == BL - 1), {4{32'(seed + k * BL + b)}}});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic end_checks(input string name, input int exp_errs);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_err"}, err, (exp_errs != 0));
    chk({name, "_err_cnt"}, err_cnt, 16'(exp_errs));
    chk({name, "_queues_drained"}, exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every DUT handshake and checks stall stability.
  initial begin : mon0
    logic         aw_stall, w_stall;
    logic [63:0]  aw_prev, ea;
    logic [128:0] w_prev, ew;
    aw_stall = 1'b0; w_stall = 1'b0; aw_prev = '0; w_prev = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) chk("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
        if (w_stall)  chk("w_stable", {wvalid, wlast, wdata}, {1'b1, w_prev});
        aw_stall = awvalid && !awready;
        aw_prev  = awaddr;
        w_stall  = wvalid && !wready;
        w_prev   = {wlast, wdata};
        if (awvalid && awready) begin
          aw_cnt++;
          if (exp_aw_q.size() == 0) miss("aw_unexpected");
          else begin
            ea = exp_aw_q.pop_front();
            chk("awaddr", awaddr, ea);
            chk("aw_len_size", {awlen, awsize}, {8'd3, 3'd4});
            chk("aw_const", {awburst, awcache, awid, awlock, awprot, awqos, awregion, awuser}, CONSTS);
          end
        end
        if (wvalid && wready) begin
          if (exp_w_q.size() == 0) miss("w_unexpected");
          else begin
            ew = exp_w_q.pop_front();
            chk("w_beat", {wstrb, wlast, wdata}, {16'hFFFF, ew});
          end
        end
        if (arvalid && arready) begin
          if (exp_ar_q.size() == 0) miss("ar_unexpected");
          else begin
            ea = exp_ar_q.pop_front();
            chk("araddr", {araddr, arlen, arsize}, {ea, 8'd3, 3'd4});
            chk("ar_const", {arburst, arcache, arid, arlock, arprot, arqos, arregion, aruser}, CONSTS);
          end
        end
      end
    end
  end

  // Slave memory for DUT 0, with optional random backpressure and fault injection.
  initial begin : slave0
    logic         aw_h, w_h, b_h, ar_h, r_h, c_wlast, b_pend, r_act;
    logic [63:0]  c_awaddr, c_araddr, wr_addr, rd_addr;
    logic [127:0] c_wdata;
    logic [127:0] mem [64];
    logic [5:0]   idx;
    int           wr_beat, rd_beat;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
    wr_addr = '0; rd_addr = '0; wr_beat = 0; rd_beat = 0; b_pend = 0; r_act = 0;
    forever begin
      @(negedge clk);
      aw_h = !areset && awvalid && awready;
      w_h  = !areset && wvalid && wready;
      b_h  = !areset && bvalid && bready;
      ar_h = !areset && arvalid && arready;
      r_h  = !areset && rvalid && rready;
      c_awaddr = awaddr; c_araddr = araddr; c_wdata = wdata; c_wlast = wlast;
      @(posedge clk); #2;
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        b_pend = 0; r_act = 0;
      end else begin
        if (aw_h) begin wr_addr = c_awaddr; wr_beat = 0; end
        if (w_h) begin
          idx = wr_addr[9:4] + 6'(wr_beat);
          mem[idx] = c_wdata;
          wr_beat++;
          if (c_wlast) b_pend = 1;
        end
        if (b_h) bvalid = 0;
        if (b_pend && !bvalid) begin
          bvalid = 1;
          b_pend = 0;
          bresp  = (int'(wr_addr[9:6]) == bresp_burst) ? 2'b10 : 2'b00;
        end
        if (ar_h) begin rd_addr = c_araddr; rd_beat = 0; r_act = 1; end
        if (r_h) begin
          rvalid = 0;
          rd_beat++;
          if (rd_beat == BL) r_act = 0;
        end
        if (r_act && !rvalid && (!bp_en || $urandom_range(0, 1) == 1)) begin
          idx    = rd_addr[9:4] + 6'(rd_beat);
          rvalid = 1;
          rdata  = mem[idx];
          if (int'(rd_addr[9:6]) == corrupt_burst && rd_beat == corrupt_beat) rdata = rdata ^ 128'h1;
          rresp  = (int'(rd_addr[9:6]) == rresp_burst && rd_beat == rresp_beat) ? 2'b11 : 2'b00;
          rlast  = (rd_beat == BL - 1);
        end
        awready = !bp_en || ($urandom_range(0, 1) == 1);
        wready  = !bp_en || ($urandom_range(0, 1) == 1);
        arready = !bp_en || ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin : mon1
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!areset) begin
        if (awvalid1 && awready1) begin
          if (exp1_aw_q.size() == 0) miss("dut1_aw_unexpected");
          else begin
            e = exp1_aw_q.pop_front();
            chk("dut1_aw", {awaddr1, awlen1, awsize1}, {e, 8'd0, 3'd2});
            chk("dut1_aw_const", {awburst1, awcache1, awid1, awlock1, awprot1, awqos1, awregion1, awuser1}, CONSTS);
          end
        end
        if (wvalid1 && wready1) begin
          if (exp1_w_q.size() == 0) miss("dut1_w_unexpected");
          else begin
            e = exp1_w_q.pop_front();
            chk("dut1_w_beat", {wlast1, wstrb1, wdata1}, {1'b1, 4'hF, e});
          end
        end
        if (arvalid1 && arready1) begin
          if (exp1_ar_q.size() == 0) miss("dut1_ar_unexpected");
          else begin
            e = exp1_ar_q.pop_front();
            chk("dut1_ar", {araddr1, arlen1, arsize1}, {e, 8'd0, 3'd2});
            chk("dut1_ar_const", {arburst1, arcache1, arid1, arlock1, arprot1, arqos1, arregion1, aruser1}, CONSTS);
          end
        end
      end
    end
  end

  // Always-ready slave for DUT 1; reads return the last written word.
  initial begin : slave1
    logic        w_h, b_h, ar_h, r_h, b_pend;
    logic [31:0] c_wdata, mem1;
    awready1 = 1; wready1 = 1; arready1 = 1; bvalid1 = 0; bresp1 = 0;
    rvalid1 = 0; rdata1 = '0; rresp1 = 0; rlast1 = 0; b_pend = 0; mem1 = '0;
    forever begin
      @(negedge clk);
      w_h  = !areset && wvalid1 && wready1;
      b_h  = !areset && bvalid1 && bready1;
      ar_h = !areset && arvalid1 && arready1;
      r_h  = !areset && rvalid1 && rready1;
      c_wdata = wdata1;
      @(posedge clk); #2;
      if (areset) begin
        bvalid1 = 0; rvalid1 = 0; b_pend = 0;
      end else begin
        if (w_h) begin mem1 = c_wdata; b_pend = 1; end
        if (b_h) bvalid1 = 0;
        if (b_pend && !bvalid1) begin bvalid1 = 1; b_pend = 0; end
        if (r_h) rvalid1 = 0;
        if (ar_h) begin rvalid1 = 1; rdata1 = mem1; rlast1 = 1; end
      end
    end
  end

  initial begin : stim
    int i;
    areset = 1; start = 0; start1 = 0; loop = 0; bp_en = 0;
    corrupt_burst = -1; corrupt_beat = -1; bresp_burst = -1; rresp_burst = -1; rresp_beat = -1;
    repeat (3) @(posedge clk);
    #1 areset = 0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, err, err_cnt, awvalid, wvalid, wlast, bready, arvalid, rready}, '0);
    chk("dut1_reset_outputs", {busy1, done1, err1, err_cnt1, awvalid1, wvalid1, arvalid1, rready1}, '0);

    // Ideal slave: addresses 0x0/0x40, data 0..3 then 4..7.
    exp_aw_q.push_back(64'h0);
    exp_aw_q.push_back(64'h40);
    if (CHK == 1) begin exp_ar_q.push_back(64'h0); exp_ar_q.push_back(64'h40); end
    for (int n = 0; n < 8; n++) exp_w_q.push_back({((n % 4) == 3), {4{32'(n)}}});
    @(posedge clk); #1 start = 1;
    @(negedge clk); chk("awvalid_before_sample", awvalid, 1'b0);
    @(posedge clk); #1 start = 0;
    @(negedge clk); chk("awvalid_latency_busy", {awvalid, busy}, 2'b11);
    wait_done(400);
    end_checks("ideal", 0);

    // Read-back corruption at burst 1 beat 2; pass restarts from DONE with seed 0.
    corrupt_burst = 1; corrupt_beat = 2;
    push_pass(0);
    pulse_start();
    chk("done_cleared_on_start", {done, busy}, 2'b01);
    wait_done(400);
    end_checks("corrupt", CHK);
    corrupt_burst = -1; corrupt_beat = -1;

    // Reset clears errors; then SLVERR on burst 0 and DECERR on burst 1 beat 0.
    @(posedge clk); #1 areset = 1;
    @(posedge clk); #1 areset = 0;
    @(negedge clk);
    chk("reset_clears_err", {err, err_cnt}, '0);
    bresp_burst = 0; rresp_burst = 1; rresp_beat = 0;
    push_pass(0);
    pulse_start();
    wait_done(400);
    end_checks("resp_err", 1 + CHK);
    bresp_burst = -1; rresp_burst = -1; rresp_beat = -1;

    // Backpressure, three looping passes; errors from before are kept.
    bp_en = 1; loop = 1;
    push_pass(0); push_pass(1); push_pass(2);
    i = aw_cnt + 2 * BN + 1;
    pulse_start();
    for (int c = 0; c < 4000 && aw_cnt < i; c++) @(negedge clk);
    chk("third_pass_reached", (aw_cnt >= i), 1'b1);
    loop = 0;
    wait_done(4000);
    end_checks("loop_bp", 1 + CHK);
    bp_en = 0;

    // Reset in the middle of a W burst.
    push_pass(0);
    pulse_start();
    for (int c = 0; c < 100 && !wvalid; c++) @(negedge clk);
    chk("reached_w", wvalid, 1'b1);
    @(posedge clk); #1 areset = 1;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_w_reset_outputs", {busy, done, err, err_cnt, awvalid, wvalid, wlast, bready, arvalid, rready}, '0);
    @(posedge clk); #1 areset = 0;

    // BURST_LEN=1 instance: one beat per burst, wlast always set.
    for (int k = 0; k < 3; k++) begin
      exp1_aw_q.push_back(32'h100 + 32'(4 * k));
      if (CHK == 1) exp1_ar_q.push_back(32'h100 + 32'(4 * k));
      exp1_w_q.push_back(32'(k));
    end
    @(posedge clk); #1 start1 = 1;
    @(posedge clk); #1 start1 = 0;
    @(negedge clk);
    for (int c = 0; c < 200 && !done1; c++) @(negedge clk);
    chk("dut1_done", {done1, busy1}, 2'b10);
    chk("dut1_err_cnt", {err1, err_cnt1}, '0);
    chk("dut1_queues_drained", exp1_aw_q.size() + exp1_w_q.size() + exp1_ar_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/axi_tg_m.md
AXI_TG_M -- requirements
Module: axi_tg_m

Interface
REQ-001 SHALL have parameter DATA_W, default 128: AXI data width, a power of 2, 32..512.
REQ-002 SHALL have parameter ADDR_W, default 64: AXI address width.
REQ-003 SHALL have parameter BURST_LEN, default 16: beats per burst, 1..256.
REQ-004 SHALL have parameter BURST_NUM, default 8: bursts per pass, at least 1.
REQ-005 SHALL have parameter BASE_ADDR, default 0: start address of the pass, aligned to DATA_W/8.
REQ-006 SHALL have port aclk, in, 1: the single clock; all logic on the rising edge.
REQ-007 SHALL have port areset, in, 1: reset, synchronous and active-high.
REQ-008 SHALL have port start, in, 1: a level sampled high in IDLE starts a pass.
REQ-009 SHALL have port loop, in, 1: sampled at the end of a pass; when high, another pass starts with the next seed.
REQ-010 SHALL have port busy, out, 1: high while a pass is in progress.
REQ-011 SHALL have port done, out, 1: high after a non-looping pass completes.
REQ-012 SHALL have port err, out, 1: sticky error flag.
REQ-013 SHALL have port err_cnt, out, 16: saturating error count.
REQ-014 SHALL have the AXI AW ports awvalid (out, 1), awready (in, 1), awaddr (out, ADDR_W), awlen (out, 8) and awsize (out, 3).
REQ-015 SHALL have the AXI W ports wvalid (out, 1), wready (in, 1), wdata (out, DATA_W), wstrb (out, DATA_W/8) and wlast (out, 1).
REQ-016 SHALL have the AXI B ports bvalid (in, 1), bready (out, 1) and bresp (in, 2).
REQ-017 SHALL have the AXI AR ports arvalid (out, 1), arready (in, 1), araddr (out, ADDR_W), arlen (out, 8) and arsize (out, 3).
REQ-018 SHALL have the AXI R ports rvalid (in, 1), rready (out, 1), rdata (in, DATA_W), rresp (in, 2) and rlast (in, 1).
REQ-019 SHALL drive these constant outputs, each 2 bits wide for awid/arid and otherwise as per AXI4: awburst/arburst = 2'b01 (INCR); awcache/arcache = 4'b0011; awid/arid = 0; awlock/arlock = 0; awprot/arprot = 0; awqos/arqos = 0; awregion/arregion = 0; awuser/aruser = 0 (18 bits).

Function
REQ-020 SHALL implement FSM states IDLE, AW, W, B, AR, R, NEXT and DONE.
REQ-021 SHALL transition: IDLE to AW on start; AW to W on the AW handshake; W to B on the handshake with wlast; B to AR on the B handshake; AR to R on the AR handshake; R to NEXT on the handshake with rlast; NEXT to AW if bursts remain, otherwise to AW (loop=1) or DONE (loop=0); DONE to AW on start.
REQ-022 SHALL drive awvalid in the cycle after start is sampled, i.e. one cycle of latency.
REQ-023 SHALL keep at most one outstanding transaction; W begins only after the AW handshake.
REQ-024 SHALL hold each valid, with its payload stable, until its ready is high; bready=1 only in B and rready=1 only in R.
REQ-025 SHALL address burst k at BASE_ADDR + k*BURST_LEN*(DATA_W/8), with awlen=arlen=BURST_LEN-1, awsize=arsize=log2(DATA_W/8) and wstrb all ones.
REQ-026 SHALL write, for beat b of burst k, wdata = DATA_W/32 copies of the 32-bit value seed + k*BURST_LEN + b, wrapping modulo 2^32.
REQ-027 SHALL assert wlast exactly on beat BURST_LEN-1; BURST_LEN=1 gives a single beat with wlast=1.
REQ-028 SHALL count one error per occurrence of: bresp != OKAY; rresp != OKAY; rdata differing from the expected pattern; rlast not on beat BURST_LEN-1.
REQ-029 SHALL, on rlast arriving early, end the burst; on rlast arriving late, count the error at beat BURST_LEN-1 and keep accepting beats until rlast arrives.
REQ-030 SHALL add at most 1 to err_cnt per cycle; the count saturates at 16'hFFFF and err is sticky.
REQ-031 SHALL zero the seed on leaving IDLE and increment it by 1 per looping pass.
REQ-032 SHALL clear done and keep err/err_cnt when start is taken from DONE.
REQ-033 SHALL hold busy=1 in every state except IDLE and DONE.

Reset
REQ-034 SHALL, on areset, enter IDLE and drive all valids, bready, rready, busy, done, err, err_cnt and seed to 0 in the next cycle.
REQ-035 SHALL abandon any transaction on reset mid-pass; the interconnect must be reset together with the block.

Configuration
REQ-036 SHALL, with AXI_TG_CHECK_EN defined, include the AR/R read-back and comparison.
REQ-037 SHALL, without AXI_TG_CHECK_EN, go from B directly to NEXT, hold arvalid=rready=0, and count bresp errors only.

Structure
REQ-038 SHALL take from package axi_tg_pkg: the state enum, AXI_BURST_INCR, AXI_RESP_OKAY and the pattern function.
REQ-039 SHALL use one sub-module, axi_tg_pat_gen, which produces the pattern word from seed, k and b; it is shared by the W path and the R check.

Verification
REQ-040 SHALL cover: BURST_LEN=4, BURST_NUM=2, DATA_W=128, ideal slave, start -> awaddr 0x0 then 0x40, data 0..3 then 4..7, done=1, err_cnt=0.
REQ-041 SHALL cover: memory corrupts one beat (burst 1, beat 2) -> err=1, err_cnt=1.
REQ-042 SHALL cover: bresp=SLVERR on burst 0 and rresp=DECERR on one beat -> err_cnt=2.
REQ-043 SHALL cover: random ready backpressure with loop=1 for 3 passes -> second pass data starts at 1 and third at 2, no errors, payloads stable while stalled.
REQ-044 SHALL cover: BURST_LEN=1 -> wlast on every beat; and areset mid-W -> next cycle IDLE with all outputs 0.
